// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state type and per-stage payload widths and NOP payloads
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, MAIN = 2'd1, BOTH = 2'd2} pipe_state_t;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] nop_PC = '0;
  localparam logic [XLEN-1:0] nop_nPC = 32'h0000_0004;
  localparam logic nop_commit = 1'b0;
  localparam logic [ILEN-1:0] nop_instr = 32'h0000_0013;
  localparam int NOP_CORE_W = 2 * XLEN + 1 + ILEN;
  localparam logic [NOP_CORE_W-1:0] nop_core = {nop_PC, nop_nPC, nop_commit, nop_instr};
  localparam int FD_PAYLOAD_W = NOP_CORE_W;
  localparam int DE_PAYLOAD_W = NOP_CORE_W + 2 * XLEN + 5 + 16;
  localparam int EM_PAYLOAD_W = NOP_CORE_W + 2 * XLEN + 5 + 12;
  localparam int MW_PAYLOAD_W = NOP_CORE_W + XLEN + 5;
  // control/operand fields below the core are zero in a bubble
  localparam logic [FD_PAYLOAD_W-1:0] FD_NOP = nop_core;
  localparam logic [DE_PAYLOAD_W-1:0] DE_NOP = {nop_core, {(DE_PAYLOAD_W - NOP_CORE_W){1'b0}}};
  localparam logic [EM_PAYLOAD_W-1:0] EM_NOP = {nop_core, {(EM_PAYLOAD_W - NOP_CORE_W){1'b0}}};
  localparam logic [MW_PAYLOAD_W-1:0] MW_NOP = {nop_core, {(MW_PAYLOAD_W - NOP_CORE_W){1'b0}}};
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: payload register with load, clear-to-NOP and hold
module pipe_entry #(
  parameter int DATA_W = 256,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk_i)
    if (rst || clr) q <= NOP_VALUE;
    else if (load) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, bubbles and optional skid entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit SKID = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [1:0]        occupancy_o
);
  logic in_xfer, out_xfer, valid_q;
  logic main_load, main_clr;
  logic [DATA_W-1:0] main_d;
  assign out_valid_o = valid_q;
  assign in_xfer = in_valid_i & in_ready_o;
  assign out_xfer = valid_q & out_ready_i;
  pipe_entry #(.DATA_W(DATA_W), .NOP_VALUE(NOP_VALUE)) u_main (
    .clk_i(clk_i), .rst(rst), .clr(main_clr), .load(main_load), .d(main_d), .q(out_data_o)
  );
  always_ff @(posedge clk_i)
    if (rst) stall_cnt_o <= '0;
    else if (valid_q && !out_ready_i && stall_cnt_o != {CNT_W{1'b1}}) stall_cnt_o <= stall_cnt_o + 1'b1;
  generate
    if (SKID) begin : g_skid
      pipe_state_t state;
      logic ready_q, skid_load, skid_clr;
      logic [DATA_W-1:0] skid_q;
      assign in_ready_o = ready_q;
      assign occupancy_o = state;
      assign main_load = (in_xfer & ((state == EMPTY) | ((state == MAIN) & out_xfer))) | ((state == BOTH) & out_xfer);
      assign main_d = (state == BOTH) ? skid_q : in_data_i;
      assign main_clr = flush_i | ((state == MAIN) & out_xfer & ~in_xfer);
      assign skid_load = (state == MAIN) & in_xfer & ~out_xfer;
      assign skid_clr = flush_i | ((state == BOTH) & out_xfer);
      pipe_entry #(.DATA_W(DATA_W), .NOP_VALUE(NOP_VALUE)) u_skid (
        .clk_i(clk_i), .rst(rst), .clr(skid_clr), .load(skid_load), .d(in_data_i), .q(skid_q)
      );
      // ready is registered: it only depends on whether both entries are full
      always_ff @(posedge clk_i)
        if (rst || flush_i) begin
          state <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end else begin
          case (state)
            EMPTY: if (in_xfer) begin
              state <= MAIN;
              valid_q <= 1'b1;
            end
            MAIN: if (in_xfer && !out_xfer) begin
              state <= BOTH;
              ready_q <= 1'b0;
            end else if (out_xfer && !in_xfer) begin
              state <= EMPTY;
              valid_q <= 1'b0;
            end
            BOTH: if (out_xfer) begin
              state <= MAIN;
              ready_q <= 1'b1;
            end
            default: begin
              state <= EMPTY;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
            end
          endcase
        end
    end else begin : g_single
      assign in_ready_o = ~valid_q | out_ready_i;
      assign occupancy_o = {1'b0, valid_q};
      assign main_load = in_xfer;
      assign main_d = in_data_i;
      assign main_clr = flush_i | (out_xfer & ~in_xfer);
      always_ff @(posedge clk_i)
        if (rst || flush_i) valid_q <= 1'b0;
        else if (in_xfer) valid_q <= 1'b1;
        else if (out_xfer) valid_q <= 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for skid (index 1) and single-entry (index 0) stages
module tb_pipe_stage_reg;
  localparam int W = 16;
  localparam logic [W-1:0] NOP = 16'hdead;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b1, out_ready = 1'b1;
  logic [W-1:0] in_data = 16'h5a5a;
  logic rdy [2];
  logic ov [2];
  logic [W-1:0] od [2];
  logic [1:0] occ [2];
  logic [3:0] sc [2];
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  int scm [2];
  bit mrdy [2];
  bit mstall [2];
  bit chk_on = 1'b0;
  int checks = 0, errs = 0;
  int n;
  logic [W-1:0] fr;
  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(4)) d1 (
    .clk_i(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
    .in_data_i(in_data), .out_valid_o(ov[1]), .out_ready_i(out_ready), .out_data_o(od[1]),
    .stall_cnt_o(sc[1]), .occupancy_o(occ[1])
  );
  pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP), .SKID(1'b0), .CNT_W(4)) d0 (
    .clk_i(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
    .in_data_i(in_data), .out_valid_o(ov[0]), .out_ready_i(out_ready), .out_data_o(od[0]),
    .stall_cnt_o(sc[0]), .occupancy_o(occ[0])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s skid=%0d got=%h exp=%h t=%0t", nm, k, a, e, $time);
    end
  endtask

  // monitor: compare every output against the FIFO model, pop on output transfer
  always @(negedge clk)
    if (chk_on)
      for (int k = 0; k < 2; k++) begin
        n = k ? q1.size() : q0.size();
        fr = NOP;
        if (n > 0) fr = k ? q1[0] : q0[0];
        mrdy[k] = k ? (n != 2) : (n == 0 || out_ready);
        chk("in_ready", k, {31'd0, rdy[k]}, {31'd0, mrdy[k]});
        chk("out_valid", k, {31'd0, ov[k]}, {31'd0, n > 0});
        chk("out_data", k, {16'd0, od[k]}, {16'd0, fr});
        chk("occupancy", k, {30'd0, occ[k]}, n);
        chk("stall_cnt", k, {28'd0, sc[k]}, scm[k]);
        mstall[k] = (n > 0) && !out_ready;
        if (n > 0 && out_ready) begin
          if (k) void'(q1.pop_front());
          else void'(q0.pop_front());
        end
      end

  // scoreboard input side: accepted payloads are pushed, flush/reset empty the model
  always @(posedge clk)
    if (rst) begin
      q0.delete();
      q1.delete();
      scm[0] = 0;
      scm[1] = 0;
      chk_on = 1'b1;
    end else
      for (int k = 0; k < 2; k++) begin
        if (mstall[k] && scm[k] < 15) scm[k]++;
        if (flush) begin
          if (k) q1.delete();
          else q0.delete();
        end else if (in_valid && mrdy[k]) begin
          if (k) q1.push_back(in_data);
          else q0.push_back(in_data);
        end
      end

  task automatic drive(input logic r, input logic v, input logic o, input logic f, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    rst = r;
    in_valid = v;
    out_ready = o;
    flush = f;
    in_data = d;
  endtask

  initial begin
    @(posedge clk);
    for (int i = 1; i <= 16; i++) drive(0, 1, 1, 0, W'(i));
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, W'(8'h20 + i));
    drive(0, 1, 1, 0, 16'h0030);
    @(negedge clk);
    chk("bp_occ", 1, {30'd0, occ[1]}, 2);
    chk("bp_ready", 1, {31'd0, rdy[1]}, 0);
    chk("bp_stall", 1, {28'd0, sc[1]}, 3);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, W'(8'h40 + i));
    drive(0, 1, 0, 0, 16'h0050);
    drive(0, 1, 0, 0, 16'h0051);
    drive(0, 1, 0, 1, 16'h0052);
    drive(0, 1, 1, 0, 16'h0053);
    @(negedge clk);
    chk("flush_occ", 1, {30'd0, occ[1]}, 0);
    chk("flush_valid", 1, {31'd0, ov[1]}, 0);
    chk("flush_ready", 1, {31'd0, rdy[1]}, 1);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, W'(8'h60 + i));
    for (int i = 0; i < 400; i++)
      drive(i == 200, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 29) == 0, W'($urandom));
    drive(1, 1, 0, 0, 16'h0100);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, W'(16'h0200 + i));
    @(negedge clk);
    chk("sat_stall", 1, {28'd0, sc[1]}, 15);
    chk("sat_stall", 0, {28'd0, sc[0]}, 15);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 16'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, synchronous flush, bubble insertion and an optional skid entry. It replaces the hand-written per-stage registers between fetch, decode, execute, memory and writeback. The payload is one packed bus of `DATA_W` bits: the stage's control, operand, branch-training and CSR fields concatenated. An invalid slot always presents a configurable NOP payload downstream.

## Interface
Parameters:
- `DATA_W`, default 256: payload width in bits, ≥1.
- `NOP_VALUE`, default 0 (`DATA_W` bits): payload driven whenever the output is invalid.
- `SKID`, default 1: 1 = two-entry skid mode with registered `in_ready_o`; 0 = single entry with combinational ready.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  kill all held entries (branch mispredict, trap, mret).
- `in_valid_i`  in  1  upstream holds a valid payload.
- `in_ready_o`  out  1  this stage accepts the payload this cycle.
- `in_data_i`  in  `DATA_W`  upstream payload.
- `out_valid_o`  out  1  `out_data_o` is a real instruction.
- `out_ready_i`  in  1  downstream consumes this cycle.
- `out_data_o`  out  `DATA_W`  payload; equals `NOP_VALUE` when `out_valid_o`=0.
- `stall_cnt_o`  out  `CNT_W`  saturating count of back-pressure cycles.
- `occupancy_o`  out  2  entries held: 0–2, never above 1 when `SKID`=0.

## Operation
- Transfer rules:
  - Input transfer = `in_valid_i & in_ready_o`.
  - Output transfer = `out_valid_o & out_ready_i`.
- Reset (`rst`=1) forces every output to its idle value:
  - `out_valid_o`=0, `out_data_o`=`NOP_VALUE`.
  - `occupancy_o`=0, `stall_cnt_o`=0.
  - `in_ready_o`=1 when `SKID`=1.
- `flush_i`=1 (with `rst`=0) has the same effect as reset on valids, data and occupancy.
  - `stall_cnt_o` is kept.
  - An input transfer in the flush cycle is discarded.
  - Reset takes priority over flush.
- `SKID`=0 (single entry):
  - `in_ready_o = ~out_valid_o | out_ready_i`.
  - On an input transfer, the entry loads `in_data_i` and becomes valid.
  - On an output transfer with no input transfer, the entry loads `NOP_VALUE` and becomes invalid (bubble).
  - Otherwise the entry holds.
- `SKID`=1 uses a main entry (drives the outputs) plus a skid entry, with states EMPTY, MAIN, BOTH:
  - EMPTY: input transfer → MAIN, main loads input.
  - MAIN, input and output transfer: stay in MAIN, main reloads.
  - MAIN, input transfer only: → BOTH, skid captures input.
  - MAIN, output transfer only: → EMPTY, main loads `NOP_VALUE`.
  - BOTH: output transfer → MAIN, main loads skid, skid cleared to `NOP_VALUE`. No input transfer is possible (`in_ready_o`=0).
  - `in_ready_o` is a register: it is 0 exactly in BOTH, so no combinational path runs from `out_ready_i` to `in_ready_o`.
- `stall_cnt_o` increments when `out_valid_o & ~out_ready_i`. It saturates at all-ones and does not wrap.
- `occupancy_o` = 0, 1 or 2 for EMPTY, MAIN and BOTH (single entry: 0 or 1).
- Payload ordering is strictly FIFO: there is no reordering and no duplication.

## Timing
- Latency is one cycle: a payload accepted on edge N appears on `out_data_o` after edge N when the stage was empty or draining.
- `out_valid_o` and `out_data_o` come directly from flops, with no combinational input-to-output path in either mode.
- Throughput is one transfer per cycle under continuous `out_ready_i`=1 in both modes.
- `SKID`=1: back-pressure reaches `in_ready_o` one cycle after `out_ready_i` falls. The skid entry absorbs the payload in flight during that cycle.
- After flush or reset, the stage accepts input on the very next cycle.
- In the flush cycle itself, the upstream sees `in_ready_o` at its pre-flush value; anything it transfers that cycle is dropped.

## Structure
- Shared package `pipe_pkg` holds:
  - the state typedef (EMPTY/MAIN/BOTH);
  - per-stage payload width constants (`DE_PAYLOAD_W`, `EM_PAYLOAD_W`, …);
  - per-stage NOP payload constants built from `nop_PC`, `nop_nPC`, `nop_commit` and `nop_instr`.
- One sub-module, `pipe_entry`: a `DATA_W`-wide register with load, clear-to-NOP and hold controls, instantiated once or twice.
- Top-level logic holds the state FSM, ready generation, the stall counter and generate-selection on `SKID`.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid_i`=1 → `out_valid_o`=0, `out_data_o`=`NOP_VALUE`, `occupancy_o`=0, `stall_cnt_o`=0.
- Streaming, `SKID`=1: send 0x01..0x10 back-to-back with `out_ready_i`=1 → 16 outputs in order, one per cycle, first one cycle after first accept.
- Back-pressure, `SKID`=1: drop `out_ready_i` for 3 cycles during the stream →
  - `occupancy_o` reaches 2, `in_ready_o`=0;
  - `stall_cnt_o`=3;
  - no payload lost or duplicated after resume.
- Flush in BOTH with `in_valid_i`=1 → next cycle `out_valid_o`=0, `occupancy_o`=0, `in_ready_o`=1; the flushed and concurrent payloads never appear.
- `SKID`=0: hold `out_valid_o`=1 with `out_ready_i`=0 → `in_ready_o`=0 the same cycle; raise `out_ready_i` with a new input → simultaneous replace, `occupancy_o` stays 1.
- Saturation with `CNT_W`=4: stall for 20 cycles → `stall_cnt_o` stops at 15.
